// File: rtl/bidir_port_pkg.sv
// Shared FSM state encoding and sizing helper for the bidirectional port.
package bidir_port_pkg;

   typedef enum logic [1:0] {
      StRx     = 2'd0,
      StTurnTx = 2'd1,
      StTx     = 2'd2,
      StTurnRx = 2'd3
   } state_e;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(value)) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/bidir_port_sync_fifo.sv
// Synchronous FIFO, power-of-two depth, push accepted when full if popped in the same cycle.
module bidir_port_sync_fifo
   import bidir_port_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign full_o  = (r_count == CW'(DEPTH));
   assign empty_o = (r_count == '0);
   assign w_pop   = pop_i & ~empty_o & ~clr_i;
   assign w_push  = push_i & (~full_o | w_pop) & ~clr_i;
   // Empty FIFO presents zero rather than a stale entry.
   assign rdata_o = empty_o ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (clr_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr_ptr] <= wdata_i;
   end

endmodule

// File: rtl/bidir_port.sv
// Half-duplex tristate port with TX/RX FIFOs and programmable turnaround gap.
// Define BIDIR_PORT_SYNC_EN to insert a 2-flop synchronizer ahead of RX capture.
module bidir_port
   import bidir_port_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned TURN  = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             dir_i,
   input  logic             clr_i,
   inout  wire  [WIDTH-1:0] data_io,
   output logic             oe_o,
   input  logic [WIDTH-1:0] tx_data_i,
   input  logic             tx_valid_i,
   output logic             tx_ready_o,
   output logic             tx_strobe_o,
   input  logic             rx_en_i,
   output logic [WIDTH-1:0] rx_data_o,
   output logic             rx_valid_o,
   input  logic             rx_ready_i,
   output logic             rx_ovf_o
);

   localparam int unsigned TW = (TURN > 1) ? clog2(TURN) : 1;

   state_e           r_state, w_state_next;
   logic [TW-1:0]    r_turn_cnt, w_turn_cnt_next;
   logic [WIDTH-1:0] r_out;
   logic             r_oe, r_strobe, r_ovf;
   logic             w_turn_done;
   logic             w_tx_pop, w_tx_full, w_tx_empty;
   logic [WIDTH-1:0] w_tx_rdata;
   logic             w_rx_sample, w_rx_pop, w_rx_full, w_rx_empty, w_rx_drop;
   logic [WIDTH-1:0] w_rx_word;

   assign w_turn_done = (r_turn_cnt == TW'(TURN - 1));

   always_comb begin
      w_state_next    = r_state;
      w_turn_cnt_next = '0;
      case (r_state)
         StRx:     if (dir_i) w_state_next = StTurnTx;
         StTurnTx: begin
            if (!dir_i)           w_state_next = StRx;
            else if (w_turn_done) w_state_next = StTx;
            else                  w_turn_cnt_next = r_turn_cnt + TW'(1);
         end
         StTx:     if (!dir_i) w_state_next = StTurnRx;
         StTurnRx: begin
            if (w_turn_done) w_state_next = StRx;
            else             w_turn_cnt_next = r_turn_cnt + TW'(1);
         end
         default:  w_state_next = StRx;
      endcase
   end

   // Pop whenever the bus will be driven next cycle, so the first word lands with oe_o.
   assign w_tx_pop   = (w_state_next == StTx) & ~w_tx_empty & ~clr_i;
   assign tx_ready_o = ~w_tx_full | w_tx_pop;

`ifdef BIDIR_PORT_SYNC_EN
   logic [WIDTH-1:0] r_sync1, r_sync2;
   logic             r_sync1_vld, r_sync2_vld;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_sync1     <= '0;
         r_sync2     <= '0;
         r_sync1_vld <= 1'b0;
         r_sync2_vld <= 1'b0;
      end else if (r_state != StRx) begin
         r_sync1_vld <= 1'b0;
         r_sync2_vld <= 1'b0;
      end else begin
         r_sync1     <= data_io;
         r_sync2     <= r_sync1;
         r_sync1_vld <= rx_en_i;
         r_sync2_vld <= r_sync1_vld;
      end
   end

   assign w_rx_word   = r_sync2;
   assign w_rx_sample = r_sync2_vld & (r_state == StRx);
`else
   assign w_rx_word   = data_io;
   assign w_rx_sample = rx_en_i & (r_state == StRx);
`endif

   assign rx_valid_o = ~w_rx_empty;
   assign w_rx_pop   = rx_valid_o & rx_ready_i;
   assign w_rx_drop  = w_rx_sample & w_rx_full & ~w_rx_pop;

   bidir_port_sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_tx_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clr_i   (clr_i),
      .push_i  (tx_valid_i & tx_ready_o),
      .wdata_i (tx_data_i),
      .pop_i   (w_tx_pop),
      .rdata_o (w_tx_rdata),
      .full_o  (w_tx_full),
      .empty_o (w_tx_empty)
   );

   bidir_port_sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_rx_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clr_i   (clr_i),
      .push_i  (w_rx_sample),
      .wdata_i (w_rx_word),
      .pop_i   (w_rx_pop),
      .rdata_o (rx_data_o),
      .full_o  (w_rx_full),
      .empty_o (w_rx_empty)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= StRx;
         r_turn_cnt <= '0;
         r_out      <= '0;
         r_oe       <= 1'b0;
         r_strobe   <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_turn_cnt <= w_turn_cnt_next;
         r_oe       <= (w_state_next == StTx);
         r_strobe   <= w_tx_pop;
         if (w_tx_pop) r_out <= w_tx_rdata;
         if (clr_i)          r_ovf <= 1'b0;
         else if (w_rx_drop) r_ovf <= 1'b1;
      end
   end

   assign oe_o        = r_oe;
   assign tx_strobe_o = r_strobe;
   assign rx_ovf_o    = r_ovf;
   assign data_io     = r_oe ? r_out : {WIDTH{1'bz}};

endmodule
